simple_uart_tx: RTL and testbench



---
 rtl/simple_uart_tx.sv | 139 +++++++++++++
 tb/tb_simple_uart_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_uart_tx.sv
// -----------------------------------------------------------------------------
// simple_uart_tx
//
// Minimal 8N1 UART transmitter. A single-cycle `start` in IDLE latches `data`
// and sends one start bit, eight data bits LSB-first and STOP_BITS stop bits,
// each held for CLKS_PER_BIT clock cycles.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit, 2..65535 (default 434)
//   STOP_BITS     number of stop bits, 1 or 2 (default 1)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous reset, active-low
//   data   in   byte to send, sampled only on the accepting edge
//   start  in   transmit request, level-sampled, honoured only in IDLE
//   busy   out  high while a frame is in progress (registered)
//   line   out  serial output, idle high (registered)
//
// State table:
//   IDLE  | line high, busy low, waiting for start
//   START | start bit (line low) for CLKS_PER_BIT cycles
//   DATA  | data bits D0..D7 from shift register bit 0
//   STOP  | stop bit(s), line high for STOP_BITS*CLKS_PER_BIT cycles
// -----------------------------------------------------------------------------
module simple_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       start,
    output logic       busy,
    output logic       line
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic          stop_cnt;
    logic [7:0]    shreg;
    logic          bit_done;

    // Bit timer runs 0..CLKS_PER_BIT-1; the last count marks a bit boundary.
    assign bit_done = (timer == T_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            busy     <= 1'b0;
            line     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    timer    <= '0;
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                    busy     <= 1'b0;
                    line     <= 1'b1;
                    if (start) begin
                        // Start bit goes out on the accepting edge itself.
                        shreg <= data;
                        state <= START;
                        busy  <= 1'b1;
                        line  <= 1'b0;
                    end
                end

                START: begin
                    if (bit_done) begin
                        timer <= '0;
                        state <= DATA;
                        line  <= shreg[0];
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            line  <= 1'b1;
                        end else begin
                            // line is registered, so it takes the bit that
                            // lands in position 0 after this shift.
                            shreg   <= {1'b0, shreg[7:1]};
                            line    <= shreg[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            state    <= IDLE;
                            stop_cnt <= 1'b0;
                            busy     <= 1'b0;
                            line     <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    timer <= '0;
                    busy  <= 1'b0;
                    line  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_uart_tx.sv
module tb_simple_uart_tx;

    localparam int C = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       start;
    logic       busy,  line;
    logic       busy2, line2;

    int tests;
    int fails;

    simple_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .start(start),
        .busy(busy), .line(line)
    );

    simple_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .data(data), .start(start),
        .busy(busy2), .line(line2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference waveform: t = cycles since the accepting edge (t=0 is the
    // output right after that edge).
    function automatic logic exp_line(input logic [7:0] b, input int t, input int s);
        if (t < 0 || t >= (9 + s) * C) return 1'b1;
        if (t < C) return 1'b0;
        if (t < 9 * C) return b[t / C - 1];
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int t, input int s);
        return (t >= 0 && t < (9 + s) * C);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] b);
        data  = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset;
        logic [7:0] b;
        b     = 8'($urandom);
        rst_n = 1'b0;
        start = 1'b1;
        data  = b;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (line !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold cyc=%0d line=%b busy=%b expected line=1 busy=0", i, line, busy);
            end
        end
        rst_n = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= 10 * C; t++) begin
            tests++;
            if (line !== exp_line(b, t, 1) || busy !== exp_busy(t, 1)) begin
                fails++;
                $display("FAIL reset_first_frame t=%0d line=%b busy=%b expected line=%b busy=%b",
                         t, line, busy, exp_line(b, t, 1), exp_busy(t, 1));
            end
            step();
        end
        idle_cycles(8);
    endtask

    task automatic test_single_frame;
        int busy_cnt;
        busy_cnt = 0;
        pulse_start(8'h55);
        for (int t = 0; t <= 10 * C + 2; t++) begin
            if (busy === 1'b1) busy_cnt++;
            tests++;
            if (line !== exp_line(8'h55, t, 1) || busy !== exp_busy(t, 1)) begin
                fails++;
                $display("FAIL single_0x55 t=%0d line=%b busy=%b expected line=%b busy=%b",
                         t, line, busy, exp_line(8'h55, t, 1), exp_busy(t, 1));
            end
            step();
        end
        tests++;
        if (busy_cnt != 10 * C) begin
            fails++;
            $display("FAIL single_busy_len got=%0d expected=%0d", busy_cnt, 10 * C);
        end
        idle_cycles(3);
    endtask

    task automatic test_random_frames;
        logic [7:0] b;
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            pulse_start(b);
            for (int t = 0; t <= 10 * C; t++) begin
                tests++;
                if (line !== exp_line(b, t, 1) || busy !== exp_busy(t, 1)) begin
                    fails++;
                    $display("FAIL random_frame byte=%02h t=%0d line=%b busy=%b expected line=%b busy=%b",
                             b, t, line, busy, exp_line(b, t, 1), exp_busy(t, 1));
                end
                step();
            end
            idle_cycles(int'($urandom_range(0, 5)));
        end
    endtask

    // Receiver model: sample mid-bit relative to the accepting edge and decode.
    task automatic test_back_to_back;
        logic [9:0] bits;
        logic [7:0] nxt;
        int         t, nframes, cyc;
        nxt     = 8'h00;
        nframes = 0;
        cyc     = 0;
        bits    = '0;
        pulse_start(nxt);
        t = 0;
        while (nframes < 6 && cyc < 2000) begin
            if ((t % C) == C / 2 && (t / C) < 10) bits[t / C] = line;
            if (t > 0 && busy === 1'b0) begin
                tests++;
                if (line !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_gap frame=%0d line=%b expected 1", nframes, line);
                end
                tests++;
                if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || bits[8:1] !== nxt) begin
                    fails++;
                    $display("FAIL b2b_decode frame=%0d start=%b stop=%b data=%02h expected start=0 stop=1 data=%02h",
                             nframes, bits[0], bits[9], bits[8:1], nxt);
                end
                nframes++;
                nxt = nxt + 8'd1;
                bits = '0;
                if (nframes < 6) begin
                    pulse_start(nxt);
                    t = 0;
                end
            end else begin
                step();
                t++;
            end
            cyc++;
        end
        tests++;
        if (nframes < 6) begin
            fails++;
            $display("FAIL b2b_timeout frames=%0d expected 6", nframes);
        end
        idle_cycles(4);
    endtask

    task automatic test_busy_ignore;
        pulse_start(8'h00);
        for (int t = 0; t <= 10 * C + 3 * C; t++) begin
            if (t == 10) begin
                data  = 8'hFF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tests++;
            if (line !== exp_line(8'h00, t, 1) || busy !== exp_busy(t, 1)) begin
                fails++;
                $display("FAIL busy_ignore t=%0d line=%b busy=%b expected line=%b busy=%b",
                         t, line, busy, exp_line(8'h00, t, 1), exp_busy(t, 1));
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_data_hold;
        pulse_start(8'hA5);
        data = 8'h5A;
        for (int t = 0; t <= 10 * C; t++) begin
            tests++;
            if (line !== exp_line(8'hA5, t, 1) || busy !== exp_busy(t, 1)) begin
                fails++;
                $display("FAIL data_hold t=%0d line=%b busy=%b expected line=%b busy=%b",
                         t, line, busy, exp_line(8'hA5, t, 1), exp_busy(t, 1));
            end
            step();
        end
        idle_cycles(3);
    endtask

    task automatic test_abort;
        logic [7:0] b;
        b = 8'($urandom) & 8'hF7;   // D3 low so the abort visibly raises line
        pulse_start(b);
        for (int t = 0; t <= 4 * C + 1; t++) begin
            tests++;
            if (line !== exp_line(b, t, 1) || busy !== exp_busy(t, 1)) begin
                fails++;
                $display("FAIL abort_pre t=%0d line=%b busy=%b expected line=%b busy=%b",
                         t, line, busy, exp_line(b, t, 1), exp_busy(t, 1));
            end
            if (t < 4 * C + 1) step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (line !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_async line=%b busy=%b expected line=1 busy=0", line, busy);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * C; i++) begin
            step();
            tests++;
            if (line !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL abort_after cyc=%0d line=%b busy=%b expected line=1 busy=0", i, line, busy);
            end
        end
    endtask

    task automatic test_stop_bits2;
        logic [7:0] b;
        int         busy_cnt;
        b        = 8'($urandom);
        busy_cnt = 0;
        pulse_start(b);
        for (int t = 0; t <= 11 * C + 2; t++) begin
            if (busy2 === 1'b1) busy_cnt++;
            tests++;
            if (line2 !== exp_line(b, t, 2) || busy2 !== exp_busy(t, 2)) begin
                fails++;
                $display("FAIL stop2 t=%0d line=%b busy=%b expected line=%b busy=%b",
                         t, line2, busy2, exp_line(b, t, 2), exp_busy(t, 2));
            end
            step();
        end
        tests++;
        if (busy_cnt != 11 * C) begin
            fails++;
            $display("FAIL stop2_busy_len got=%0d expected=%0d", busy_cnt, 11 * C);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        data  = 8'h00;
        test_reset();
        test_single_frame();
        test_random_frames();
        test_back_to_back();
        test_busy_ignore();
        test_data_hold();
        test_abort();
        test_stop_bits2();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
